// File: rtl/state_mixcol_unit_pkg.sv
// state_mixcol_unit_pkg
//   Shared definitions for the MixColumns sequencing unit:
//   - state_t     : controller states
//   - xtime/gmul  : GF(2^8) arithmetic, reduction polynomial 0x11B
//   - FWD_COEF /
//     INV_COEF    : first matrix row {c0,c1,c2,c3}; row r uses the row
//                   rotated right by r
package state_mixcol_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] FWD_COEF = 32'h0203_0101;
  localparam logic [31:0] INV_COEF = 32'h0e0b_0d09;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = x;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/state_mixcol_unit_colmix_word.sv
// colmix_word
//   Combinational MixColumns / InvMixColumns of one 32-bit column.
//   Ports:
//     i_col : column in, byte a in bits [31:24], then b, c, d
//     i_inv : 0 forward, 1 inverse
//     o_col : transformed column, same byte order
module colmix_word
  import state_mixcol_unit_pkg::*;
(
  input  logic [31:0] i_col,
  input  logic        i_inv,
  output logic [31:0] o_col
);

  logic [31:0] w_coef;
  logic [7:0]  w_acc;

  always_comb begin
    w_coef = i_inv ? INV_COEF : FWD_COEF;
    o_col  = '0;
    w_acc  = '0;
    for (int r = 0; r < 4; r++) begin
      w_acc = '0;
      // output byte r takes coefficient (i - r) mod 4 for input byte i
      for (int i = 0; i < 4; i++) begin
        w_acc = w_acc ^ gmul(i_col[31-8*i -: 8], w_coef[31-8*((i-r+4)%4) -: 8]);
      end
      o_col[31-8*r -: 8] = w_acc;
    end
  end

endmodule

// File: rtl/state_mixcol_unit.sv
// state_mixcol_unit
//   Applies (Inv)MixColumns to an NB-column state, CPC columns per clock,
//   with a valid/ready handshake on both sides.
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     in_valid / in_ready   : input handshake
//     in_state              : state, column 0 in the MSBs
//     in_decrypt, in_bypass : mode bits, captured at accept
//     out_valid / out_ready : output handshake
//     out_state             : result, same layout as in_state
//     busy                  : transform in progress
//
//   state | meaning
//   IDLE  | waiting for a state to accept
//   RUN   | transforming one column group per clock
//   DONE  | result held on out_state until out_ready
module state_mixcol_unit
  import state_mixcol_unit_pkg::*;
#(
  parameter int NB  = 4,
  parameter int CPC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [32*NB-1:0] in_state,
  input  logic            in_decrypt,
  input  logic            in_bypass,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*NB-1:0] out_state,
  output logic            busy
);

  localparam int NG = NB / CPC;
  localparam int CW = (NG > 1) ? $clog2(NG) : 1;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [31:0]    r_cols [NB];
  logic           r_dec;
  logic           r_byp;
  logic           r_live;
  logic [31:0]    w_grp_in  [CPC];
  logic [31:0]    w_grp_mix [CPC];
  logic           w_accept;
  logic           w_last;

  // r_live keeps in_ready low while reset is applied and for the edge it
  // is released on, so the first acceptable edge is the one after.
  assign in_ready  = r_live && ((r_state == ST_IDLE) ||
                                ((r_state == ST_DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == CW'(NG - 1));
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_RUN;
      ST_RUN:  if (w_last)   w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = w_accept ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Column group selected by the counter feeds the CPC transform lanes.
  always_comb begin
    for (int k = 0; k < CPC; k++) w_grp_in[k] = '0;
    for (int j = 0; j < NB; j++) begin
      if (r_cnt == CW'(j / CPC)) w_grp_in[j % CPC] = r_cols[j];
    end
  end

  for (genvar k = 0; k < CPC; k++) begin : g_lane
    colmix_word u_colmix (
      .i_col (w_grp_in[k]),
      .i_inv (r_dec),
      .o_col (w_grp_mix[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_dec  <= 1'b0;
      r_byp  <= 1'b0;
      r_live <= 1'b0;
      for (int j = 0; j < NB; j++) r_cols[j] <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        for (int j = 0; j < NB; j++) r_cols[j] <= in_state[32*(NB-1-j) +: 32];
        r_dec <= in_decrypt;
        r_byp <= in_bypass;
        r_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        // bypass still walks the groups so latency is mode-independent
        for (int j = 0; j < NB; j++) begin
          if ((r_cnt == CW'(j / CPC)) && !r_byp) r_cols[j] <= w_grp_mix[j % CPC];
        end
        r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    out_state = '0;
    for (int j = 0; j < NB; j++) out_state[32*(NB-1-j) +: 32] = r_cols[j];
  end

endmodule

// File: tb/tb_state_mixcol_unit.sv
// Bench for state_mixcol_unit: four instances (NB/CPC = 4/1, 4/2, 4/4, 8/2)
// share data/mode/out_ready/rst; each has its own in_valid.
module tb_state_mixcol_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] in_state;
  logic         in_decrypt;
  logic         in_bypass;
  logic         out_ready;
  logic [3:0]   iv;
  wire  [3:0]   ir;
  wire  [3:0]   ov;
  wire  [3:0]   bz;
  wire  [127:0] os0;
  wire  [127:0] os1;
  wire  [127:0] os2;
  wire  [255:0] os3;

  int n_checks = 0;
  int n_fail   = 0;
  int max_cnt  = 0;

  always #5 clk = ~clk;

  state_mixcol_unit #(.NB(4), .CPC(1)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_state(in_state[127:0]), .in_decrypt(in_decrypt), .in_bypass(in_bypass),
    .out_valid(ov[0]), .out_ready(out_ready), .out_state(os0), .busy(bz[0]));
  state_mixcol_unit #(.NB(4), .CPC(2)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_state(in_state[127:0]), .in_decrypt(in_decrypt), .in_bypass(in_bypass),
    .out_valid(ov[1]), .out_ready(out_ready), .out_state(os1), .busy(bz[1]));
  state_mixcol_unit #(.NB(4), .CPC(4)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_state(in_state[127:0]), .in_decrypt(in_decrypt), .in_bypass(in_bypass),
    .out_valid(ov[2]), .out_ready(out_ready), .out_state(os2), .busy(bz[2]));
  state_mixcol_unit #(.NB(8), .CPC(2)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_state(in_state), .in_decrypt(in_decrypt), .in_bypass(in_bypass),
    .out_valid(ov[3]), .out_ready(out_ready), .out_state(os3), .busy(bz[3]));

  always @(negedge clk) if (int'(u_d3.r_cnt) > max_cnt) max_cnt = int'(u_d3.r_cnt);

  localparam logic [7:0] MF [4][4] = '{'{8'h02, 8'h03, 8'h01, 8'h01},
                                       '{8'h01, 8'h02, 8'h03, 8'h01},
                                       '{8'h01, 8'h01, 8'h02, 8'h03},
                                       '{8'h03, 8'h01, 8'h01, 8'h02}};
  localparam logic [7:0] MI [4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09},
                                       '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                                       '{8'h0d, 8'h09, 8'h0e, 8'h0b},
                                       '{8'h0b, 8'h0d, 8'h09, 8'h0e}};

  // Russian-peasant multiply in GF(2^8)
  function automatic logic [7:0] gm(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = '0;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [255:0] model(input int nb, input logic [255:0] st,
                                         input bit dec, input bit byp);
    logic [255:0] res;
    logic [31:0]  col, nc;
    logic [7:0]   acc;
    res = '0;
    for (int c = 0; c < nb; c++) begin
      col = st[32*(nb-1-c) +: 32];
      nc  = col;
      if (!byp) begin
        for (int r = 0; r < 4; r++) begin
          acc = '0;
          for (int i = 0; i < 4; i++)
            acc = acc ^ gm(dec ? MI[r][i] : MF[r][i], col[31-8*i -: 8]);
          nc[31-8*r -: 8] = acc;
        end
      end
      res[32*(nb-1-c) +: 32] = nc;
    end
    return res;
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] get_os(input int d);
    case (d)
      0:       return {128'b0, os0};
      1:       return {128'b0, os1};
      2:       return {128'b0, os2};
      default: return os3;
    endcase
  endfunction

  function automatic int nb_of(input int d);
    return (d == 3) ? 8 : 4;
  endfunction

  function automatic int ng_of(input int d);
    case (d)
      0:       return 4;
      1:       return 2;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int d);
    int n = 0;
    while (!ir[d] && n < 100) begin step(); n++; end
    n_checks++;
    if (ir[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_ready dut%0d: in_ready=%b required 1 within 100 cycles", d, ir[d]);
    end
  endtask

  task automatic start(input int d, input logic [255:0] st, input bit dec, input bit byp);
    in_state   = st;
    in_decrypt = dec;
    in_bypass  = byp;
    iv[d]      = 1'b1;
  endtask

  task automatic wait_done(input int d, input string name);
    int n = 0;
    while (!ov[d] && n < 50) begin step(); n++; end
    n_checks++;
    if (n != ng_of(d) || ov[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s latency dut%0d: got %0d cycles (out_valid=%b) required %0d", name, d, n, ov[d], ng_of(d));
    end
  endtask

  // one transaction: accept, scramble inputs during RUN, check latency and result
  task automatic run_txn(input int d, input logic [255:0] st, input bit dec, input bit byp,
                         input logic [255:0] exp_st, input string name);
    wait_ready(d);
    start(d, st, dec, byp);
    step();
    iv[d] = 1'b0;
    n_checks++;
    if (bz[d] !== 1'b1 || ir[d] !== 1'b0 || ov[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s run_flags dut%0d: busy=%b in_ready=%b out_valid=%b required 1 0 0", name, d, bz[d], ir[d], ov[d]);
    end
    in_state   = rnd256();
    in_decrypt = ~dec;
    in_bypass  = ~byp;
    wait_done(d, name);
    n_checks++;
    if (get_os(d) !== exp_st) begin
      n_fail++;
      $display("FAIL %s data dut%0d: got %h required %h", name, d, get_os(d), exp_st);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; iv = '0; out_ready = 1'b0;
    in_state = '0; in_decrypt = 1'b0; in_bypass = 1'b0;
    repeat (3) step();
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if (ir[d] !== 1'b0 || ov[d] !== 1'b0 || bz[d] !== 1'b0 || get_os(d) !== '0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: in_ready=%b out_valid=%b busy=%b out_state=%h required all 0",
                 d, ir[d], ov[d], bz[d], get_os(d));
      end
    end
    rst = 1'b0;
    n_checks++;
    if (ir !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release_early: in_ready=%b required 0000", ir);
    end
    step();
    n_checks++;
    if (ir !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b required 1111", ir);
    end
  endtask

  task automatic test_known();
    logic [255:0] enc_in, enc_out, dec_in, dec_out;
    enc_in  = {128'b0, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
    enc_out = {128'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
    dec_in  = {128'b0, 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8};
    dec_out = {128'b0, 128'hdb135345_f20a225c_d4d4d4d5_2d26314c};
    run_txn(0, enc_in, 1'b0, 1'b0, enc_out, "known_enc_c1");
    run_txn(0, dec_in, 1'b1, 1'b0, dec_out, "known_dec_c1");
    run_txn(1, dec_in, 1'b1, 1'b0, dec_out, "known_dec_c2");
    run_txn(2, dec_in, 1'b1, 1'b0, dec_out, "known_dec_c4");
    run_txn(2, enc_in, 1'b0, 1'b0, enc_out, "known_enc_c4");
  endtask

  task automatic test_bypass();
    logic [255:0] st;
    for (int d = 0; d < 4; d++) begin
      st = (d == 3) ? {128'h00112233445566778899aabbccddeeff, 128'hffeeddccbbaa99887766554433221100}
                    : {128'b0, 128'h00112233445566778899aabbccddeeff};
      run_txn(d, st, d[0], 1'b1, st, "bypass");
    end
  endtask

  task automatic test_model_modes();
    logic [255:0] st;
    bit dec;
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        st  = rnd256();
        if (d != 3) st[255:128] = '0;
        dec = k[0];
        run_txn(d, st, dec, 1'b0, model(nb_of(d), st, dec, 1'b0), "model_modes");
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] st, exp_st;
    wait_ready(0);
    st = {128'b0, rnd256() >> 128};
    exp_st = model(4, st, 1'b0, 1'b0);
    start(0, st, 1'b0, 1'b0);
    step();
    iv[0] = 1'b0;
    wait_done(0, "stall_first");
    for (int k = 0; k < 5; k++) begin
      out_ready = 1'b0;
      in_state  = rnd256();
      step();
      n_checks++;
      if (os0 !== exp_st[127:0] || ir[0] !== 1'b0 || ov[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold cycle%0d: out_state=%h in_ready=%b out_valid=%b required %h 0 1",
                 k, os0, ir[0], ov[0], exp_st[127:0]);
      end
    end
    st = {128'b0, rnd256() >> 128};
    exp_st = model(4, st, 1'b1, 1'b0);
    start(0, st, 1'b1, 1'b0);
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (ir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: in_ready=%b required 1", ir[0]);
    end
    step();
    iv[0] = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (bz[0] !== 1'b1 || ov[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b out_valid=%b required 1 0", bz[0], ov[0]);
    end
    wait_done(0, "b2b_second");
    n_checks++;
    if (os0 !== exp_st[127:0]) begin
      n_fail++;
      $display("FAIL b2b_data: got %h required %h", os0, exp_st[127:0]);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [255:0] st;
    int seen;
    wait_ready(0);
    start(0, {128'b0, rnd256() >> 128}, 1'b0, 1'b0);
    step();
    iv[0] = 1'b0;
    step();
    n_checks++;
    if (bz[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre busy=%b required 1", bz[0]);
    end
    rst = 1'b1;
    step();
    n_checks++;
    if (bz[0] !== 1'b0 || ov[0] !== 1'b0 || ir[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b out_valid=%b in_ready=%b required 0 0 0", bz[0], ov[0], ir[0]);
    end
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ov[0]) seen++;
    end
    n_checks++;
    if (seen != 0 || ir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_no_valid: out_valid pulses=%0d in_ready=%b required 0 and 1", seen, ir[0]);
    end
    st = {128'b0, rnd256() >> 128};
    run_txn(0, st, 1'b0, 1'b0, model(4, st, 1'b0, 1'b0), "after_abort");
  endtask

  task automatic test_random_nb8();
    logic [255:0] st, exp_st;
    bit dec;
    int stall;
    max_cnt = 0;
    wait_ready(3);
    st = rnd256(); dec = 1'($urandom_range(0, 1));
    exp_st = model(8, st, dec, 1'b0);
    start(3, st, dec, 1'b0);
    step();
    iv[3] = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      wait_done(3, "rand");
      n_checks++;
      if (os3 !== exp_st) begin
        n_fail++;
        $display("FAIL rand_data txn%0d: got %h required %h", t, os3, exp_st);
      end
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) begin
        out_ready = 1'b0;
        step();
        n_checks++;
        if (os3 !== exp_st || ov[3] !== 1'b1) begin
          n_fail++;
          $display("FAIL rand_stall txn%0d: out_state=%h out_valid=%b required %h 1", t, os3, ov[3], exp_st);
        end
      end
      out_ready = 1'b1;
      if (t < 999 && $urandom_range(0, 1) == 1) begin
        st = rnd256(); dec = 1'($urandom_range(0, 1));
        exp_st = model(8, st, dec, 1'b0);
        start(3, st, dec, 1'b0);
        step();
        iv[3] = 1'b0;
        out_ready = 1'b0;
      end else begin
        step();
        out_ready = 1'b0;
        if (t < 999) begin
          wait_ready(3);
          st = rnd256(); dec = 1'($urandom_range(0, 1));
          exp_st = model(8, st, dec, 1'b0);
          start(3, st, dec, 1'b0);
          step();
          iv[3] = 1'b0;
        end
      end
    end
    n_checks++;
    if (max_cnt != 3) begin
      n_fail++;
      $display("FAIL rand_counter_max: got %0d required 3", max_cnt);
    end
  endtask

  initial begin
    #2_000_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_known();
    test_bypass();
    test_model_modes();
    test_back_to_back();
    test_reset_mid_run();
    test_random_nb8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
